axi_mem_sram: RTL and testbench
===============================

// Module: axi_mem_sram
// PURPOSE
// - Single-port, byte-writable SRAM backing store. Consumes the memory-side port of the AXI-to-memory adapter
//   (req/we/addr/be/wdata in, rdata out, fixed 1-cycle read latency).
// - Sits directly downstream of the adapter. Decodes a base-relative address window and flags out-of-window accesses.
// - Optionally zero-fills its contents after reset.
// PARAMETERS
// - AXI_ADDR_WIDTH  64           width of addr_i (byte address)
// - AXI_DATA_WIDTH  64           word width; BYTES = AXI_DATA_WIDTH/8, LOG_NR_BYTES = $clog2(BYTES)
// - NUM_WORDS       1024         depth in words, power of two >= 2; IDX_W = $clog2(NUM_WORDS)
// - BASE_ADDR       64'h8000_0000 byte address of word 0, aligned to NUM_WORDS*BYTES
// PORTS
// - clk_i         in   1                  clock, all state on rising edge
// - rst_ni        in   1                  reset; asynchronous, active-low
// - req_i         in   1                  access request this cycle
// - we_i          in   1                  1 = write, 0 = read (qualified by req_i)
// - addr_i        in   AXI_ADDR_WIDTH     byte address; bits [LOG_NR_BYTES-1:0] ignored
// - be_i          in   AXI_DATA_WIDTH/8   byte enables for writes; ignored on reads
// - data_i        in   AXI_DATA_WIDTH     write data
// - data_o        out  AXI_DATA_WIDTH     read data, valid the cycle after a read request
// - init_done_o   out  1                  1 = array accepts accesses
// - err_o         out  1                  sticky out-of-window access flag
// - err_addr_o    out  AXI_ADDR_WIDTH     addr_i of the access that set err_o
// - err_clr_i     in   1                  clears err_o and err_addr_o
// BEHAVIOUR
// - Reset values: data_o = 0, err_o = 0, err_addr_o = 0; init_done_o per CONFIGURATION.
// - Reset during any operation (including INIT) aborts it immediately. Array contents are not reset.
// - Decode:
//   - off = addr_i - BASE_ADDR, computed modulo 2^AXI_ADDR_WIDTH.
//   - in_win = (off < NUM_WORDS*BYTES).
//   - idx = off[LOG_NR_BYTES +: IDX_W].
// - Write, cycle N (req_i & we_i & in_win & init_done_o):
//   - mem[idx] byte k <= data_i byte k for each k with be_i[k] = 1. Other bytes are unchanged.
//   - be_i = 0 is a legal no-op.
//   - data_o is unchanged.
// - Read, cycle N (req_i & !we_i & in_win & init_done_o): data_o = mem[idx] from cycle N+1.
//   - data_o is registered and holds until the next read completes.
//   - Repeated reads of the same address every cycle return the same data (adapter re-issues while r_ready is low).
// - Out of window (req_i & !in_win & init_done_o):
//   - Writes are dropped.
//   - Reads load data_o = 0 at N+1.
//   - If err_o == 0: err_o <= 1 and err_addr_o <= addr_i. A later error keeps the first address.
// - err_clr_i: err_o <= 0, err_addr_o <= 0. If a new error occurs in the same cycle, the error wins: flag set, new address captured.
// - While init_done_o == 0, req_i is ignored: no array access, data_o unchanged, no error logged. Upstream must hold off.
// - Single port: one access per cycle. No read/write collision is possible.
// CONFIGURATION
// - Macro AXI_MEM_ZERO_INIT_EN.
// - Defined:
//   - FSM INIT -> READY. Reset enters INIT with init_done_o = 0 and counter = 0.
//   - INIT writes mem[counter] = 0 each cycle and increments counter.
//   - On counter == NUM_WORDS-1: write that word, then go to READY. init_done_o = 1 from the next cycle, i.e. NUM_WORDS cycles after reset release.
//   - READY is terminal until reset.
// - Undefined: no FSM or counter. init_done_o is constant 1, including during reset. Contents are uninitialised (X in simulation).
// TESTING
// - Write/read: write 0x1122334455667788 at BASE_ADDR+0x10, be=0xFF -> read at cycle N gives that value on data_o at N+1.
// - Byte lanes: word 0 = 0; write 0xFFFF_FFFF_FFFF_FFFF with be=0x0F, read -> data_o = 0x0000_0000_FFFF_FFFF.
// - Window edges: read at BASE_ADDR+NUM_WORDS*8-8 -> data, no error; read at BASE_ADDR+NUM_WORDS*8 -> data_o = 0, err_o = 1, err_addr_o = that address.
// - Error capture: second bad access at BASE_ADDR-8 keeps the first address; err_clr_i with a new bad access in the same cycle -> err_o stays 1, err_addr_o = new address.
// - Hold/repeat: read 0xA5A5 word, then idle 5 cycles -> data_o stable; back-to-back reads of the same address -> identical data every cycle.
// - AXI_MEM_ZERO_INIT_EN: NUM_WORDS = 16 -> init_done_o rises 16 cycles after reset release; a write issued during INIT is dropped; all words read 0.
//   Reset asserted at INIT cycle 5 -> count restarts and the full 16 cycles elapse again.

Source files
------------

// File: rtl/axi_mem_sram.sv
// rtl/axi_mem_sram.sv - byte-writable single-port SRAM behind the AXI-to-memory adapter
//
// Purpose: word-organised SRAM with a 1-cycle registered read, per-byte write
// enables, a base-relative address window and a sticky out-of-window error log.
// Optional feature macro: AXI_MEM_ZERO_INIT_EN (zero-fill all words after reset).
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   req_i/we_i   access request / write select
//   addr_i       byte address (low LOG_NR_BYTES bits ignored)
//   be_i         write byte enables
//   data_i       write data
//   data_o       registered read data, valid the cycle after a read
//   init_done_o  array accepts accesses
//   err_o        sticky out-of-window flag
//   err_addr_o   address of the access that first set err_o
//   err_clr_i    clears err_o / err_addr_o
module axi_mem_sram #(
  parameter int unsigned               AXI_ADDR_WIDTH = 64,
  parameter int unsigned               AXI_DATA_WIDTH = 64,
  parameter int unsigned               NUM_WORDS      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 64'h8000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i,
  output logic [AXI_DATA_WIDTH-1:0]   data_o,
  output logic                        init_done_o,
  output logic                        err_o,
  output logic [AXI_ADDR_WIDTH-1:0]   err_addr_o,
  input  logic                        err_clr_i
);

  localparam int unsigned BYTES        = AXI_DATA_WIDTH / 8;
  localparam int unsigned LOG_NR_BYTES = $clog2(BYTES);
  localparam int unsigned IDX_W        = $clog2(NUM_WORDS);
  localparam logic [AXI_ADDR_WIDTH-1:0] WIN_BYTES =
      AXI_ADDR_WIDTH'(NUM_WORDS) << LOG_NR_BYTES;

  logic [AXI_DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  // Address decode; the subtraction wraps so addresses below BASE_ADDR fall out of window.
  logic [AXI_ADDR_WIDTH-1:0] off;
  logic                      in_win;
  logic [IDX_W-1:0]          idx;
  assign off    = addr_i - BASE_ADDR;
  assign in_win = (off < WIN_BYTES);
  assign idx    = off[LOG_NR_BYTES +: IDX_W];

  logic             init_done_q;
  logic             init_busy;
  logic [IDX_W-1:0] init_idx;

`ifdef AXI_MEM_ZERO_INIT_EN
  typedef enum logic {S_INIT, S_READY} state_e;
  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(NUM_WORDS - 1)) begin
            state_q     <= S_READY;
            init_done_q <= 1'b1;
          end
        end
        default: state_q <= S_READY;
      endcase
    end
  end

  // Gated by rst_ni so a held reset does not keep scrubbing word 0.
  assign init_busy = (state_q == S_INIT) && rst_ni;
  assign init_idx  = cnt_q;
`else
  assign init_done_q = 1'b1;
  assign init_busy   = 1'b0;
  assign init_idx    = '0;
`endif

  logic acc, wr, rd;
  assign acc = req_i & init_done_q;
  assign wr  = acc & we_i & in_win;
  assign rd  = acc & ~we_i;

  // Single write port shared between the zero-fill sequencer and normal writes.
  logic                      mem_we;
  logic [IDX_W-1:0]          mem_idx;
  logic [BYTES-1:0]          mem_be;
  logic [AXI_DATA_WIDTH-1:0] mem_wdata;
  assign mem_we    = init_busy | wr;
  assign mem_idx   = init_busy ? init_idx : idx;
  assign mem_be    = init_busy ? '1 : be_i;
  assign mem_wdata = init_busy ? '0 : data_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < BYTES; k++) begin
        if (mem_be[k]) mem_q[mem_idx][k*8 +: 8] <= mem_wdata[k*8 +: 8];
      end
    end
  end

  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic                      err_q, err_d;
  logic [AXI_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  // A new error in the same cycle as a clear wins and captures the new address.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_clr_i) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
    if (acc && !in_win && (!err_q || err_clr_i)) begin
      err_d      = 1'b1;
      err_addr_d = addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (rd) data_q <= in_win ? mem_q[idx] : '0;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign data_o      = data_q;
  assign init_done_o = init_done_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_axi_mem_sram.sv
// tb/tb_axi_mem_sram.sv - scoreboard bench for axi_mem_sram
module tb_axi_mem_sram;

  localparam int          NW   = 16;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic [63:0] addr_i = '0;
  logic [63:0] data_i = '0;
  logic [7:0]  be_i = '0;
  logic [63:0] data_o, err_addr_o;
  logic        init_done_o, err_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mem_m [NW];
  logic [63:0] exp_q [$];
  logic [63:0] exp_v;
  bit          model_ready = 1'b1;

  axi_mem_sram #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .NUM_WORDS(NW),
    .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_i(req_i),
    .we_i(we_i),
    .addr_i(addr_i),
    .be_i(be_i),
    .data_i(data_i),
    .data_o(data_o),
    .init_done_o(init_done_o),
    .err_o(err_o),
    .err_addr_o(err_addr_o),
    .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit m_in_win(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return off < 64'(NW * 8);
  endfunction

  function automatic int m_idx(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return int'(off[6:3]);
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a);
    if (!m_in_win(a)) return 64'h0;
    return mem_m[m_idx(a)];
  endfunction

  // Drives one cycle of stimulus and keeps the reference memory up to date.
  task automatic cyc(input logic req, input logic we, input logic [63:0] a,
                     input logic [7:0] be, input logic [63:0] d, input logic clr);
    req_i = req; we_i = we; addr_i = a; be_i = be; data_i = d; err_clr_i = clr;
    if (req && we && model_ready && m_in_win(a)) begin
      for (int k = 0; k < 8; k++)
        if (be[k]) mem_m[m_idx(a)][k*8 +: 8] = d[k*8 +: 8];
    end
    @(posedge clk_i);
    #1;
    req_i = 1'b0; we_i = 1'b0; err_clr_i = 1'b0; be_i = '0;
  endtask

  task automatic test_reset();
    int n;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++; if (data_o !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", data_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err_o); end
    n_cmp++; if (err_addr_o !== 64'h0) begin n_bad++; $display("FAIL reset_err_addr: got %h expected 0", err_addr_o); end
`ifdef AXI_MEM_ZERO_INIT_EN
    n_cmp++; if (init_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %b expected 0", init_done_o); end
`else
    n_cmp++; if (init_done_o !== 1'b1) begin n_bad++; $display("FAIL reset_init_done: got %b expected 1", init_done_o); end
`endif
    rst_ni = 1'b1;
    n = 0;
    while (init_done_o !== 1'b1 && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
`ifdef AXI_MEM_ZERO_INIT_EN
    n_cmp++; if (n != NW) begin n_bad++; $display("FAIL init_latency: got %0d expected %0d", n, NW); end
    for (int i = 0; i < NW; i++) mem_m[i] = 64'h0;
`else
    n_cmp++; if (n != 0) begin n_bad++; $display("FAIL init_latency: got %0d expected 0", n); end
`endif
  endtask

`ifdef AXI_MEM_ZERO_INIT_EN
  task automatic test_zero_init();
    int n;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_ready = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
    cyc(1'b1, 1'b1, BASE + 64'h10, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    cyc(1'b1, 1'b0, BASE + 64'h400, 8'h00, 64'h0, 1'b0);
    n = 6;
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL init_no_err: got %b expected 0", err_o); end
    n_cmp++; if (data_o !== 64'h0) begin n_bad++; $display("FAIL init_data_hold: got %h expected 0", data_o); end
    while (init_done_o !== 1'b1 && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    n_cmp++; if (n != NW) begin n_bad++; $display("FAIL init_latency2: got %0d expected %0d", n, NW); end
    model_ready = 1'b1;
    for (int i = 0; i < NW; i++) mem_m[i] = 64'h0;
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back(m_read(BASE + 64'(i * 8)));
      cyc(1'b1, 1'b0, BASE + 64'(i * 8), 8'h00, 64'h0, 1'b0);
      exp_v = exp_q.pop_front();
      n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL init_zero_word%0d: got %h expected %h", i, data_o, exp_v); end
    end
    // Reset in the middle of INIT restarts the full sequence.
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (init_done_o !== 1'b0) begin n_bad++; $display("FAIL init_abort: got %b expected 0", init_done_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    n = 0;
    while (init_done_o !== 1'b1 && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    n_cmp++; if (n != NW) begin n_bad++; $display("FAIL init_restart: got %0d expected %0d", n, NW); end
  endtask
`endif

  task automatic test_write_read();
    logic [63:0] prev;
    prev = data_o;
    cyc(1'b1, 1'b1, BASE + 64'h10, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
    n_cmp++; if (data_o !== prev) begin n_bad++; $display("FAIL write_data_hold: got %h expected %h", data_o, prev); end
    exp_q.push_back(m_read(BASE + 64'h10));
    cyc(1'b1, 1'b0, BASE + 64'h10, 8'h00, 64'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL write_read: got %h expected %h", data_o, exp_v); end
    // Low address bits are ignored; read via an unaligned address of the same word.
    cyc(1'b1, 1'b1, BASE + 64'h18, 8'hFF, 64'h0BAD_F00D_CAFE_0001, 1'b0);
    exp_q.push_back(m_read(BASE + 64'h18));
    cyc(1'b1, 1'b0, BASE + 64'h1B, 8'h00, 64'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL unaligned_read: got %h expected %h", data_o, exp_v); end
  endtask

  task automatic test_byte_lanes();
    cyc(1'b1, 1'b1, BASE, 8'hFF, 64'h0, 1'b0);
    cyc(1'b1, 1'b1, BASE, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    exp_q.push_back(64'h0000_0000_FFFF_FFFF);
    cyc(1'b1, 1'b0, BASE, 8'h00, 64'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL byte_lanes_low: got %h expected %h", data_o, exp_v); end
    cyc(1'b1, 1'b1, BASE, 8'hA0, 64'h1111_2222_3333_4444, 1'b0);
    cyc(1'b1, 1'b1, BASE, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    exp_q.push_back(m_read(BASE));
    cyc(1'b1, 1'b0, BASE, 8'h00, 64'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL byte_lanes_mix: got %h expected %h", data_o, exp_v); end
  endtask

  task automatic test_window_edges();
    cyc(1'b1, 1'b1, BASE + 64'h78, 8'hFF, 64'h5A5A_0F0F_1234_ABCD, 1'b0);
    exp_q.push_back(m_read(BASE + 64'h78));
    cyc(1'b1, 1'b0, BASE + 64'h78, 8'h00, 64'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL win_last: got %h expected %h", data_o, exp_v); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL win_last_err: got %b expected 0", err_o); end
    exp_q.push_back(m_read(BASE + 64'h80));
    cyc(1'b1, 1'b0, BASE + 64'h80, 8'h00, 64'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL win_past_data: got %h expected %h", data_o, exp_v); end
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL win_past_err: got %b expected 1", err_o); end
    n_cmp++; if (err_addr_o !== BASE + 64'h80) begin n_bad++; $display("FAIL win_past_addr: got %h expected %h", err_addr_o, BASE + 64'h80); end
    // An out-of-window write that would alias word 2 must be dropped.
    cyc(1'b1, 1'b1, BASE + 64'h90, 8'hFF, 64'hFFFF_0000_FFFF_0000, 1'b0);
    exp_q.push_back(m_read(BASE + 64'h10));
    cyc(1'b1, 1'b0, BASE + 64'h10, 8'h00, 64'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL win_write_drop: got %h expected %h", data_o, exp_v); end
  endtask

  task automatic test_error_capture();
    cyc(1'b1, 1'b0, BASE - 64'h8, 8'h00, 64'h0, 1'b0);
    n_cmp++; if (err_addr_o !== BASE + 64'h80) begin n_bad++; $display("FAIL err_keep_first: got %h expected %h", err_addr_o, BASE + 64'h80); end
    cyc(1'b1, 1'b1, BASE + 64'h1000, 8'hFF, 64'h0, 1'b1);
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_clr_race_flag: got %b expected 1", err_o); end
    n_cmp++; if (err_addr_o !== BASE + 64'h1000) begin n_bad++; $display("FAIL err_clr_race_addr: got %h expected %h", err_addr_o, BASE + 64'h1000); end
    cyc(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1);
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_clr_flag: got %b expected 0", err_o); end
    n_cmp++; if (err_addr_o !== 64'h0) begin n_bad++; $display("FAIL err_clr_addr: got %h expected 0", err_addr_o); end
  endtask

  task automatic test_hold_repeat();
    cyc(1'b1, 1'b1, BASE + 64'h28, 8'hFF, 64'h0000_0000_0000_A5A5, 1'b0);
    exp_q.push_back(m_read(BASE + 64'h28));
    cyc(1'b1, 1'b0, BASE + 64'h28, 8'h00, 64'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL hold_read: got %h expected %h", data_o, exp_v); end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
      n_cmp++; if (data_o !== 64'hA5A5) begin n_bad++; $display("FAIL hold_idle%0d: got %h expected %h", i, data_o, 64'hA5A5); end
    end
    cyc(1'b1, 1'b1, BASE + 64'h30, 8'hFF, 64'h7777_7777_7777_7777, 1'b0);
    n_cmp++; if (data_o !== 64'hA5A5) begin n_bad++; $display("FAIL hold_on_write: got %h expected %h", data_o, 64'hA5A5); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(m_read(BASE + 64'h10));
      cyc(1'b1, 1'b0, BASE + 64'h10, 8'h00, 64'h0, 1'b0);
      exp_v = exp_q.pop_front();
      n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL b2b_same%0d: got %h expected %h", i, data_o, exp_v); end
    end
    for (int i = 0; i < 6; i++) begin
      a = BASE + 64'($urandom_range(0, NW - 1) * 8);
      cyc(1'b1, 1'b1, a, 8'($urandom), {$urandom, $urandom}, 1'b0);
    end
    foreach (mem_m[i]) begin
      if (i == 0 || i == 2 || i == 3 || i == 5 || i == 6 || i == 15) begin
        a = BASE + 64'(i * 8);
        exp_q.push_back(m_read(a));
        cyc(1'b1, 1'b0, a, 8'h00, 64'h0, 1'b0);
        exp_v = exp_q.pop_front();
        n_cmp++; if (data_o !== exp_v) begin n_bad++; $display("FAIL b2b_word%0d: got %h expected %h", i, data_o, exp_v); end
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef AXI_MEM_ZERO_INIT_EN
    test_zero_init();
`endif
    test_write_read();
    test_byte_lanes();
    test_window_edges();
    test_error_capture();
    test_hold_repeat();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
